// File: rtl/rr_throttle_arbiter.sv
// rr_throttle_arbiter: round-robin arbiter that shares one cell block among
// NUM_REQ requesters. Each grant has a bounded length (HOLD_MAX), every release
// is followed by a cool-down gap (COOL_CYCLES), and THROTTLE holds off new grants.
// Optional grant/preemption statistics are compiled in with RR_ARB_STATS_EN.
module rr_throttle_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_MAX    = 8,
  parameter int COOL_CYCLES = 2,
  localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               CK,
  input  logic               RN,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic [NUM_REQ-1:0] DONE,
  input  logic               THROTTLE,
  output logic [NUM_REQ-1:0] GNT,
  output logic [IDW-1:0]     GNT_ID,
  output logic               BUSY,
  output logic               PREEMPT
`ifdef RR_ARB_STATS_EN
  ,
  output logic [15:0]        PREEMPT_CNT,
  output logic [15:0]        GRANT_CNT
`endif
);

  localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam int CW = (COOL_CYCLES > 0) ? $clog2(COOL_CYCLES + 1) : 1;

  localparam logic [HW-1:0] HOLD_LIM  = HW'(HOLD_MAX);
  localparam logic [CW-1:0] COOL_INIT = CW'(COOL_CYCLES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_COOL  = 2'd2;

  logic [1:0]         r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [IDW-1:0]     r_gntId;
  logic [IDW-1:0]     r_last;
  logic               r_busy;
  logic               r_preempt;
  logic [HW-1:0]      r_holdCnt;
  logic [CW-1:0]      r_coolCnt;

  logic [IDW-1:0]     w_sel;
  logic [IDW-1:0]     w_idx;
  logic               w_found;
  logic               w_curDone;
  logic               w_curReq;
  logic               w_holdHit;
  logic               w_release;
  logic               w_grantNow;

  // Round-robin search: first set REQ bit starting just after the last grantee.
  always_comb begin
    w_sel   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDW'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && REQ[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_curDone  = DONE[r_gntId];
  assign w_curReq   = REQ[r_gntId];
  assign w_holdHit  = (HOLD_MAX != 0) && (r_holdCnt == HOLD_LIM);
  assign w_release  = (r_state == S_GRANT) && (w_curDone || !w_curReq || w_holdHit);
  assign w_grantNow = (r_state == S_IDLE) && !THROTTLE && w_found;

  // Main FSM: IDLE arbitrates, GRANT tracks hold length, COOL enforces the gap.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_gntId   <= '0;
      r_last    <= IDW'(NUM_REQ - 1);
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
      r_holdCnt <= '0;
      r_coolCnt <= '0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grantNow) begin
            r_state   <= S_GRANT;
            r_gnt     <= NUM_REQ'(1) << w_sel;
            r_gntId   <= w_sel;
            r_last    <= w_sel;
            r_busy    <= 1'b1;
            r_holdCnt <= HW'(1);
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_gnt     <= '0;
            r_holdCnt <= '0;
            r_preempt <= w_holdHit && !w_curDone && w_curReq;
            if (COOL_CYCLES > 0) begin
              r_state   <= S_COOL;
              r_coolCnt <= COOL_INIT;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (r_holdCnt < HOLD_LIM) begin
            r_holdCnt <= r_holdCnt + 1'b1;
          end
        end
        S_COOL: begin
          if (r_coolCnt <= CW'(1)) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_coolCnt <= '0;
          end else begin
            r_coolCnt <= r_coolCnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign GNT     = r_gnt;
  assign GNT_ID  = r_gntId;
  assign BUSY    = r_busy;
  assign PREEMPT = r_preempt;

`ifdef RR_ARB_STATS_EN
  logic [15:0] r_preemptCnt;
  logic [15:0] r_grantCnt;

  // Saturating counters of preemption pulses and issued grants.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_preemptCnt <= '0;
      r_grantCnt   <= '0;
    end else begin
      if (r_preempt && (r_preemptCnt != 16'hFFFF)) begin
        r_preemptCnt <= r_preemptCnt + 16'd1;
      end
      if (w_grantNow && (r_grantCnt != 16'hFFFF)) begin
        r_grantCnt <= r_grantCnt + 16'd1;
      end
    end
  end

  assign PREEMPT_CNT = r_preemptCnt;
  assign GRANT_CNT   = r_grantCnt;
`endif

endmodule

// File: tb/tb_rr_throttle_arbiter.sv
// tb_rr_throttle_arbiter: directed scoreboard bench for rr_throttle_arbiter
// with default parameters (NUM_REQ=4, HOLD_MAX=8, COOL_CYCLES=2).
// Statistics outputs are checked when RR_ARB_STATS_EN is defined.
module tb_rr_throttle_arbiter;

  logic       CK;
  logic       RN;
  logic [3:0] REQ;
  logic [3:0] DONE;
  logic       THROTTLE;
  logic [3:0] GNT;
  logic [1:0] GNT_ID;
  logic       BUSY;
  logic       PREEMPT;
`ifdef RR_ARB_STATS_EN
  logic [15:0] PREEMPT_CNT;
  logic [15:0] GRANT_CNT;
`endif

  int checkCount = 0;
  int errorCount = 0;

  // One expected grant: vector, index, length in cycles (-1 = not checked),
  // whether PREEMPT accompanies its release, and GNT=0 cycles before it (-1 = not checked).
  typedef struct {
    logic [3:0] gnt;
    int         id;
    int         len;
    logic       preempt;
    int         gap;
  } expGrant_t;

  expGrant_t expQ[$];
  int expGrants   = 0;
  int expPreempts = 0;

  rr_throttle_arbiter dut (
    .CK(CK),
    .RN(RN),
    .REQ(REQ),
    .DONE(DONE),
    .THROTTLE(THROTTLE),
    .GNT(GNT),
    .GNT_ID(GNT_ID),
    .BUSY(BUSY),
    .PREEMPT(PREEMPT)
`ifdef RR_ARB_STATS_EN
    ,
    .PREEMPT_CNT(PREEMPT_CNT),
    .GRANT_CNT(GRANT_CNT)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] done, input logic thr);
    REQ      = req;
    DONE     = done;
    THROTTLE = thr;
  endtask

  task automatic pushExp(input logic [3:0] gnt, input int id, input int len,
                         input logic preempt, input int gap);
    expGrant_t e;
    e.gnt     = gnt;
    e.id      = id;
    e.len     = len;
    e.preempt = preempt;
    e.gap     = gap;
    expQ.push_back(e);
    expGrants++;
    if (preempt) expPreempts++;
  endtask

  task automatic waitGnt(input bit wantNonZero, input int bound, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge CK);
      hit = wantNonZero ? (GNT != '0) : (GNT == '0);
    end
    if (!hit) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL %s: no GNT change after %0d cycles, expected one", name, bound);
    end
  endtask

  task automatic pulseReset();
    RN = 1'b0;
    expGrants   = 0;
    expPreempts = 0;
    #2;
    RN = 1'b1;
  endtask

  // Monitor: pops an expectation at each grant start and checks the release.
  initial begin
    logic [3:0] prevGnt;
    int         cyc;
    int         startCyc;
    int         lastRel;
    bit         haveCur;
    expGrant_t  cur;
    prevGnt  = '0;
    cyc      = 0;
    startCyc = 0;
    lastRel  = 0;
    haveCur  = 1'b0;
    cur      = '{gnt: '0, id: 0, len: -1, preempt: 1'b0, gap: -1};
    forever begin
      @(negedge CK);
      cyc++;
      if (GNT != '0 && prevGnt == '0) begin
        if (expQ.size() == 0) begin
          checkCount++;
          errorCount++;
          $display("[TB] FAIL unexpected_grant: got GNT=%b, expected no grant", GNT);
          haveCur = 1'b0;
        end else begin
          cur     = expQ.pop_front();
          haveCur = 1'b1;
          checkOutput("grant_vec", int'(GNT), int'(cur.gnt));
          checkOutput("grant_id", int'(GNT_ID), cur.id);
          if (cur.gap >= 0) checkOutput("grant_gap", cyc - lastRel, cur.gap);
        end
        startCyc = cyc;
      end else if (GNT == '0 && prevGnt != '0) begin
        if (haveCur) begin
          if (cur.len >= 0) checkOutput("grant_len", cyc - startCyc, cur.len);
          checkOutput("preempt_at_release", int'(PREEMPT), int'(cur.preempt));
        end
        haveCur = 1'b0;
        lastRel = cyc;
      end else if (PREEMPT === 1'b1) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL stray_preempt: got PREEMPT=1 at cycle %0d, expected 0", cyc);
      end
      prevGnt = GNT;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected the bench to complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus.
  initial begin
    RN = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    #7;
    checkOutput("reset_gnt", int'(GNT), 0);
    checkOutput("reset_busy", int'(BUSY), 0);
    checkOutput("reset_preempt", int'(PREEMPT), 0);
    checkOutput("reset_gnt_id", int'(GNT_ID), 0);
    @(negedge CK);
    RN = 1'b1;

    // Two requesters, no DONE: both are preempted after 8 cycles, in RR order 1 then 2.
    // The gap is the 2 cool cycles plus the IDLE arbitration cycle.
    $display("[TB] hold-limit preemption with REQ=0110");
    pushExp(4'b0010, 1, 8, 1'b1, -1);
    pushExp(4'b0100, 2, 8, 1'b1, 3);
    applyStimulus(4'b0110, 4'b0000, 1'b0);
    @(negedge CK);
    checkOutput("first_grant_vec", int'(GNT), 2);
    checkOutput("first_grant_id", int'(GNT_ID), 1);
    checkOutput("first_grant_busy", int'(BUSY), 1);
    waitGnt(1'b0, 12, "preempt_release_wait");
    checkOutput("cool1_busy", int'(BUSY), 1);
    @(negedge CK);
    checkOutput("cool2_busy", int'(BUSY), 1);
    checkOutput("cool2_gnt", int'(GNT), 0);
    @(negedge CK);
    checkOutput("idle_after_cool_busy", int'(BUSY), 0);
    waitGnt(1'b1, 4, "second_grant_wait");
    waitGnt(1'b0, 12, "second_release_wait");
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    repeat (4) @(negedge CK);
    checkOutput("drain_gnt", int'(GNT), 0);
    checkOutput("drain_busy", int'(BUSY), 0);

    // All four requesting, DONE on the 3rd grant cycle; other DONE bits ignored.
    $display("[TB] round robin with REQ=1111");
    pulseReset();
    pushExp(4'b0001, 0, 3, 1'b0, -1);
    pushExp(4'b0010, 1, 3, 1'b0, 3);
    pushExp(4'b0100, 2, 3, 1'b0, 3);
    pushExp(4'b1000, 3, 3, 1'b0, 3);
    pushExp(4'b0001, 0, 3, 1'b0, 3);
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    for (int g = 0; g < 5; g++) begin
      waitGnt(1'b1, 6, "rr_grant_wait");
      DONE = ~GNT;
      @(negedge CK);
      @(negedge CK);
      DONE = GNT;
      @(negedge CK);
      DONE = 4'b0000;
      if (g == 4) REQ = 4'b0000;
    end
    repeat (4) @(negedge CK);

    // THROTTLE while idle blocks the grant; once dropped, grant follows next cycle.
    $display("[TB] throttle while idle");
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CK);
      checkOutput("throttle_idle_gnt", int'(GNT), 0);
    end
    checkOutput("throttle_idle_busy", int'(BUSY), 0);
    pushExp(4'b0001, 0, 4, 1'b0, -1);
    THROTTLE = 1'b0;
    @(negedge CK);
    checkOutput("throttle_drop_gnt", int'(GNT), 1);

    // THROTTLE rising mid-grant does not cut the grant; it blocks the next one.
    $display("[TB] throttle mid-grant");
    @(negedge CK);
    THROTTLE = 1'b1;
    @(negedge CK);
    @(negedge CK);
    DONE = 4'b0001;
    @(negedge CK);
    DONE = 4'b0000;
    checkOutput("throttle_release_busy", int'(BUSY), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge CK);
      checkOutput("throttle_hold_off_gnt", int'(GNT), 0);
    end
    checkOutput("throttle_hold_off_busy", int'(BUSY), 0);

    // Asynchronous reset mid-grant, then the search restarts at 0 and wraps to 3.
    $display("[TB] reset mid-grant");
    pushExp(4'b1000, 3, -1, 1'b0, -1);
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    @(negedge CK);
    checkOutput("pre_reset_gnt", int'(GNT), 8);
    @(negedge CK);
    #2;
    RN = 1'b0;
    expGrants   = 0;
    expPreempts = 0;
    #1;
    checkOutput("async_reset_gnt", int'(GNT), 0);
    checkOutput("async_reset_busy", int'(BUSY), 0);
    checkOutput("async_reset_gnt_id", int'(GNT_ID), 0);
    checkOutput("async_reset_preempt", int'(PREEMPT), 0);
    pushExp(4'b1000, 3, 8, 1'b1, -1);
    @(negedge CK);
    RN = 1'b1;
    @(negedge CK);
    checkOutput("wrap_after_reset_gnt", int'(GNT), 8);
    checkOutput("wrap_after_reset_id", int'(GNT_ID), 3);
    waitGnt(1'b0, 12, "wrap_release_wait");
    REQ = 4'b0000;
    repeat (4) @(negedge CK);

    // Two requesters alternate; preempted ones wait their turn, then DONE and REQ drop release.
    $display("[TB] alternating preemption with REQ=0011");
    pushExp(4'b0001, 0, 8, 1'b1, -1);
    pushExp(4'b0010, 1, 8, 1'b1, 3);
    pushExp(4'b0001, 0, 2, 1'b0, 3);
    pushExp(4'b0010, 1, 2, 1'b0, 3);
    applyStimulus(4'b0011, 4'b0000, 1'b0);
    waitGnt(1'b1, 4, "alt_grant0_wait");
    waitGnt(1'b0, 12, "alt_release0_wait");
    waitGnt(1'b1, 6, "alt_grant1_wait");
    waitGnt(1'b0, 12, "alt_release1_wait");
    waitGnt(1'b1, 6, "alt_grant2_wait");
    @(negedge CK);
    DONE = 4'b0001;
    @(negedge CK);
    DONE = 4'b0000;
    waitGnt(1'b1, 6, "alt_grant3_wait");
    @(negedge CK);
    REQ = 4'b0000;
    @(negedge CK);
    repeat (4) @(negedge CK);
    checkOutput("final_gnt", int'(GNT), 0);
    checkOutput("final_busy", int'(BUSY), 0);
    checkOutput("scoreboard_drained", expQ.size(), 0);

`ifdef RR_ARB_STATS_EN
    checkOutput("stats_preempt_cnt", int'(PREEMPT_CNT), expPreempts);
    checkOutput("stats_grant_cnt", int'(GRANT_CNT), expGrants);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
